// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: registered one-hot grant held until done.
// Define ARB_TIMEOUT_EN to force release after max_hold cycles in BUSY.
module rr_grant_scheduler #(
    parameter int req_count = 4,
    parameter int max_hold = 16,
    localparam int idx_width = $clog2(req_count)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [req_count-1:0] req,
    input  logic                 done,
    output logic [req_count-1:0] grant,
    output logic [idx_width-1:0] grant_idx,
    output logic                 grant_valid,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } state_t;

    localparam logic [idx_width:0] wrap = (idx_width+1)'(req_count);
    localparam logic [idx_width-1:0] last = idx_width'(req_count - 1);
    localparam logic [req_count-1:0] one = req_count'(1);

    state_t               state;
    logic [idx_width-1:0] ptr;
    logic [req_count-1:0] rot;
    logic [idx_width:0]   sum;
    logic [idx_width-1:0] win;
    logic [idx_width-1:0] nxt_ptr;
    logic                 found;
    logic                 expire;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then unrotate.
    always_comb begin
        rot = req_count'({req, req} >> ptr);
        found = 1'b0;
        sum = '0;
        for (int i = req_count - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                sum = (idx_width+1)'(i);
            end
        end
        sum = sum + {1'b0, ptr};
        if (sum >= wrap) begin
            sum = sum - wrap;
        end
        win = sum[idx_width-1:0];
    end

    assign nxt_ptr = (grant_idx == last) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE, RELEASE: begin
                    if (enable && found) begin
                        state       <= BUSY;
                        grant       <= one << win;
                        grant_idx   <= win;
                        grant_valid <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (done || expire) begin
                        state       <= RELEASE;
                        ptr         <= nxt_ptr;
                        grant       <= '0;
                        grant_idx   <= '0;
                        grant_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant       <= '0;
                    grant_idx   <= '0;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int cnt_width = $clog2(max_hold + 1);

    logic [cnt_width-1:0] cnt;

    assign expire = (state == BUSY) && (cnt == cnt_width'(max_hold - 1));

    // Counter is zero on the first BUSY cycle since BUSY is always
    // entered from a non-BUSY state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= expire && !done;
            if (state == BUSY) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Testbench for rr_grant_scheduler: directed cases plus random traffic
// against a queue-free behavioural round-robin model.
module tb_rr_grant_scheduler;

    localparam int N  = 4;
    localparam int MH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    logic       enable3;
    logic [2:0] req3;
    logic       done3;
    logic [2:0] grant3;
    logic [1:0] grant_idx3;
    logic       grant_valid3;
    logic       timeout3;

    int n_checks = 0;
    int n_fail = 0;

    int   m_owner;
    int   m_ptr;
    int   m_hold;
    logic m_to;

    always #5 clk = ~clk;

    rr_grant_scheduler #(.req_count(N), .max_hold(MH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .req(req), .done(done),
        .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid),
        .timeout(timeout)
    );

    rr_grant_scheduler #(.req_count(3), .max_hold(MH)) dut3 (
        .clk(clk), .reset(reset), .enable(enable3), .req(req3), .done(done3),
        .grant(grant3), .grant_idx(grant_idx3), .grant_valid(grant_valid3),
        .timeout(timeout3)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int p, input logic [3:0] r);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (p + k) % N;
            if (((r >> c) & 4'd1) != 4'd0) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr = 0;
        m_hold = 0;
        m_to = 1'b0;
    endtask

    // Model: an owner holds until done (or hold limit); the cycle after a
    // release has no owner, and any ownerless edge arbitrates from m_ptr.
    task automatic model_edge();
        bit hit;
        int w;
        if (m_owner >= 0) begin
            m_hold++;
            hit = 1'b0;
`ifdef ARB_TIMEOUT_EN
            hit = (m_hold >= MH);
`endif
            if (done || hit) begin
                m_to = !done;
                m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_to = 1'b0;
            end
        end else begin
            m_to = 1'b0;
            if (enable) begin
                w = pick(m_ptr, req);
                if (w >= 0) begin
                    m_owner = w;
                    m_hold = 0;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] eg;
        eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        check("grant", 32'(grant), 32'(eg));
        check("grant_idx", 32'(grant_idx),
              32'((m_owner >= 0) ? m_owner : 0));
        check("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        check("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic settle();
        enable = 1'b0;
        done = 1'b1;
        step();
        step();
        done = 1'b0;
    endtask

    int   seq[$];
    int   run;
    int   max_run;
    logic saw_to;

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        req = '0;
        done = 1'b0;
        enable3 = 1'b0;
        req3 = '0;
        done3 = 1'b0;
        model_reset();
        #12;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_idx", 32'(grant_idx), 32'd0);
        check("rst_valid", 32'(grant_valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_grant3", 32'(grant3), 32'd0);
        reset = 1'b0;

        // enable low: nothing granted, done in IDLE ignored
        req = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            done = (i == 2);
            step();
            check("en0_grant", 32'(grant), 32'd0);
        end
        done = 1'b0;
        enable = 1'b1;
        step();
        check("en1_grant", 32'(grant), 32'b0010);

        // grant to 1, release; req 0011 in dead cycle wraps to 0
        done = 1'b1;
        step();
        check("dead_cycle", 32'(grant), 32'd0);
        done = 1'b0;
        req = 4'b0011;
        step();
        check("wrap_grant", 32'(grant), 32'b0001);
        settle();

        // rotation with done held high
        seq.delete();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
        req = 4'b1111;
        enable = 1'b1;
        done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (grant_valid) seq.push_back(int'(grant_idx));
        end
        check("rot_len", 32'(seq.size()), 32'd5);
        for (int i = 0; i < 5 && i < seq.size(); i++) begin
            check("rot_idx", 32'(seq[i]), 32'(i % N));
        end
        settle();

        // async reset in BUSY with grant 0100
        req = 4'b0100;
        enable = 1'b1;
        step();
        check("pre_rst", 32'(grant), 32'b0100);
        #2;
        reset = 1'b1;
        #1;
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_idx", 32'(grant_idx), 32'd0);
        check("arst_valid", 32'(grant_valid), 32'd0);
        model_reset();
        #1;
        reset = 1'b0;
        req = 4'b1111;
        step();
        check("post_rst_idx", 32'(grant_idx), 32'd0);
        settle();

        // three requesters, non-power-of-2 wrap
        enable3 = 1'b1;
        req3 = 3'b100;
        @(posedge clk);
        #1;
        check("n3_first", 32'(grant3), 32'b100);
        check("n3_first_idx", 32'(grant_idx3), 32'd2);
        done3 = 1'b1;
        @(posedge clk);
        #1;
        check("n3_dead", 32'(grant3), 32'd0);
        done3 = 1'b0;
        req3 = 3'b011;
        @(posedge clk);
        #1;
        check("n3_second", 32'(grant3), 32'b001);
        check("n3_second_idx", 32'(grant_idx3), 32'd0);
        enable3 = 1'b0;
        req3 = '0;
        model_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            req = 4'($urandom);
            enable = ($urandom % 4) != 0;
            done = ($urandom % 3) == 0;
            step();
        end
        settle();

        // hold limit behaviour
        req = 4'b0001;
        enable = 1'b1;
        run = 0;
        max_run = 0;
        saw_to = 1'b0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (grant_valid) run++;
            else run = 0;
            if (run > max_run) max_run = run;
            if (timeout) saw_to = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        check("to_seen", 32'(saw_to), 32'd1);
        check("to_run", 32'(max_run), 32'(MH));
`else
        check("hold_grant", 32'(grant), 32'b0001);
        check("hold_run", 32'(max_run >= 100), 32'd1);
        check("to_never", 32'(saw_to), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
